// File: rtl/mul_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mul_seq_pkg
// Purpose  : Op encodings and FSM state codes for the multiply sequencer.
// Revision : 1.0  initial release
// ============================================================================
package mul_seq_pkg;

    localparam logic [1:0] MUL_OP_LO  = 2'd0;
    localparam logic [1:0] MUL_OP_XUU = 2'd1;
    localparam logic [1:0] MUL_OP_XSS = 2'd2;
    localparam logic [1:0] MUL_OP_XSU = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ISSUE_LO = 3'd1;
    localparam state_t ST_WAIT_LO  = 3'd2;
    localparam state_t ST_ISSUE_HI = 3'd3;
    localparam state_t ST_WAIT_HI  = 3'd4;
    localparam state_t ST_RESP     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/mul_result_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mul_result_sequencer_if
// Purpose  : Request, partial-product cell and result buses of the sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface mul_result_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    // Environment side: issues requests, hosts the cell, consumes results.
    modport master (
        output req_valid, req_op, req_a, req_b,
        output cell_p1, cell_p2, cell_p3,
        output res_ready,
        input  req_ready, cell_src1, cell_src2, cell_en, res_valid, res_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  cell_p1, cell_p2, cell_p3,
        input  res_ready,
        output req_ready, cell_src1, cell_src2, cell_en, res_valid, res_data
    );

endinterface
`default_nettype wire

// File: rtl/mul_hi_correct.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mul_hi_correct
// Purpose  : Turns the unsigned high product word into the signed variants.
// Revision : 1.0  initial release
// ============================================================================
module mul_hi_correct
    import mul_seq_pkg::*;
(
    input  logic [31:0] full_hi_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  op_i,
    output logic [31:0] hi_o
);

    logic [31:0] w_corr_a;
    logic [31:0] w_corr_b;

    // A negative signed operand contributes -2^32 * other operand to the product.
    always_comb begin
        w_corr_a = '0;
        w_corr_b = '0;
        if ((op_i == MUL_OP_XSS || op_i == MUL_OP_XSU) && a_i[31]) begin
            w_corr_a = b_i;
        end
        if (op_i == MUL_OP_XSS && b_i[31]) begin
            w_corr_b = a_i;
        end
        hi_o = full_hi_i - w_corr_a - w_corr_b;
    end

endmodule
`default_nettype wire

// File: rtl/mul_result_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mul_result_sequencer
// Purpose  : Drives the shared 16x16 cell over one or two passes and assembles
//            the 32-bit low or high multiply result.
// Revision : 1.0  initial release
// ============================================================================
module mul_result_sequencer
    import mul_seq_pkg::*;
#(
    parameter int CELL_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mul_result_sequencer_if.slave   bus
);

    localparam logic [1:0] CNT_INIT = 2'(CELL_LATENCY - 1);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [16:0] acc_hi_q, acc_hi_d;
    logic [31:0] res_q, res_d;

    logic [32:0] w_mid;
    logic [48:0] w_acc;
    logic [31:0] w_full_hi;
    logic [31:0] w_hi_corr;

    assign w_mid = {1'b0, bus.cell_p2} + {1'b0, bus.cell_p3};
    assign w_acc = {17'b0, bus.cell_p1} + {w_mid, 16'b0};

    // Only acc[48:32] is kept: the low word is final after the first pass and
    // adding hiA*hiB << 32 can only touch bits 63:32.
    assign w_full_hi = {15'b0, acc_hi_q} + bus.cell_p1;

    mul_hi_correct u_hi_correct (
        .full_hi_i (w_full_hi),
        .a_i       (a_q),
        .b_i       (b_q),
        .op_i      (op_q),
        .hi_o      (w_hi_corr)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        res_d    = res_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    state_d = ST_ISSUE_LO;
                end
            end
            ST_ISSUE_LO: begin
                cnt_d   = CNT_INIT;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (cnt_q == 2'd0) begin
                    acc_hi_d = w_acc[48:32];
                    if (op_q == MUL_OP_LO) begin
                        res_d   = w_acc[31:0];
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE_HI;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_ISSUE_HI: begin
                cnt_d   = CNT_INIT;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (cnt_q == 2'd0) begin
                    res_d   = w_hi_corr;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            res_q    <= res_d;
        end
    end

    // Outputs decode straight from the state register so reset clears them at once.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.res_valid = (state_q == ST_RESP);
        bus.res_data  = res_q;
        bus.cell_en   = 1'b0;
        bus.cell_src1 = '0;
        bus.cell_src2 = '0;
        if (state_q == ST_ISSUE_LO) begin
            bus.cell_en   = 1'b1;
            bus.cell_src1 = a_q;
            bus.cell_src2 = b_q;
        end else if (state_q == ST_ISSUE_HI) begin
            bus.cell_en   = 1'b1;
            bus.cell_src1 = {16'h0, a_q[31:16]};
            bus.cell_src2 = {16'h0, b_q[31:16]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_result_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_result_sequencer
// Purpose  : Randomised bench for the sequencer at cell latencies 1 and 3.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_result_sequencer;
    import mul_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [1:0]        req_valid;
    logic [1:0]        res_ready;
    logic [1:0][1:0]   req_op;
    logic [1:0][31:0]  req_a;
    logic [1:0][31:0]  req_b;
    logic [1:0]        req_ready;
    logic [1:0]        res_valid;
    logic [1:0]        cell_en;
    logic [1:0][31:0]  res_data;
    logic [1:0][31:0]  cell_src1;
    logic [1:0][31:0]  cell_src2;
    logic [1:0][31:0]  en_cnt;
    logic [1:0][31:0]  last_src1;
    logic [1:0][31:0]  last_src2;
    logic [1:0][31:0]  src_viol;

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        mul_result_sequencer_if u_if ();

        mul_result_sequencer #(.CELL_LATENCY(LAT)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (u_if.slave)
        );

        assign u_if.req_valid = req_valid[g];
        assign u_if.req_op    = req_op[g];
        assign u_if.req_a     = req_a[g];
        assign u_if.req_b     = req_b[g];
        assign u_if.res_ready = res_ready[g];
        assign req_ready[g]   = u_if.req_ready;
        assign res_valid[g]   = u_if.res_valid;
        assign res_data[g]    = u_if.res_data;
        assign cell_en[g]     = u_if.cell_en;
        assign cell_src1[g]   = u_if.cell_src1;
        assign cell_src2[g]   = u_if.cell_src2;

        // Cell model: products registered on cell_en, then delayed LAT-1 more edges.
        logic [31:0] s1 [LAT];
        logic [31:0] s2 [LAT];
        logic [31:0] s3 [LAT];
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < LAT; i++) begin
                    s1[i] <= '0;
                    s2[i] <= '0;
                    s3[i] <= '0;
                end
            end else begin
                if (u_if.cell_en) begin
                    s1[0] <= 32'(u_if.cell_src1[15:0])  * 32'(u_if.cell_src2[15:0]);
                    s2[0] <= 32'(u_if.cell_src1[15:0])  * 32'(u_if.cell_src2[31:16]);
                    s3[0] <= 32'(u_if.cell_src1[31:16]) * 32'(u_if.cell_src2[15:0]);
                end
                for (int i = 1; i < LAT; i++) begin
                    s1[i] <= s1[i-1];
                    s2[i] <= s2[i-1];
                    s3[i] <= s3[i-1];
                end
            end
        end
        assign u_if.cell_p1 = s1[LAT-1];
        assign u_if.cell_p2 = s2[LAT-1];
        assign u_if.cell_p3 = s3[LAT-1];

        logic [31:0] en_n = '0;
        logic [31:0] ls1  = '0;
        logic [31:0] ls2  = '0;
        logic [31:0] viol = '0;
        always @(posedge clk) begin
            if (u_if.cell_en) begin
                en_n <= en_n + 1;
                ls1  <= u_if.cell_src1;
                ls2  <= u_if.cell_src2;
            end
        end
        always @(negedge clk) begin
            if (!u_if.cell_en && (u_if.cell_src1 != '0 || u_if.cell_src2 != '0)) begin
                viol <= viol + 1;
            end
        end
        assign en_cnt[g]    = en_n;
        assign last_src1[g] = ls1;
        assign last_src2[g] = ls2;
        assign src_viol[g]  = viol;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full 64-bit product of the sign/zero-extended operands.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == MUL_OP_XSS || op == MUL_OP_XSU) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == MUL_OP_XSS) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == MUL_OP_LO) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_req(input int sel, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int hold, input bit early);
        int          lat;
        int          lcell;
        int          elat;
        logic [31:0] en0;
        logic [31:0] exp;
        logic [31:0] held;
        lcell = (sel == 0) ? 1 : 3;
        elat  = (op == MUL_OP_LO) ? 2 + lcell : 3 + 2 * lcell;
        exp   = ref_result(op, a, b);

        @(negedge clk);
        check_eq("req_ready_idle", req_ready[sel], 1);
        en0            = en_cnt[sel];
        req_valid[sel] = 1'b1;
        req_op[sel]    = op;
        req_a[sel]     = a;
        req_b[sel]     = b;
        res_ready[sel] = early;
        @(posedge clk);
        #1;
        req_valid[sel] = 1'b0;
        req_a[sel]     = $urandom;
        req_b[sel]     = $urandom;
        req_op[sel]    = 2'($urandom_range(0, 3));
        lat = 1;
        while (!res_valid[sel] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, elat);
        check_eq("res_data", res_data[sel], exp);
        check_eq("req_ready_busy", req_ready[sel], 0);
        if (!early) begin
            held = res_data[sel];
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                req_valid[sel] = (i == 1);
                @(posedge clk);
                #1;
                req_valid[sel] = 1'b0;
                check_eq("bp_valid", res_valid[sel], 1);
                check_eq("bp_data", res_data[sel], held);
                check_eq("bp_ready", req_ready[sel], 0);
            end
            @(negedge clk);
            res_ready[sel] = 1'b1;
        end
        @(posedge clk);
        #1;
        res_ready[sel] = 1'b0;
        check_eq("release_valid", res_valid[sel], 0);
        check_eq("release_ready", req_ready[sel], 1);
        check_eq("cell_en_pulses", en_cnt[sel] - en0, (op == MUL_OP_LO) ? 1 : 2);
        check_eq("last_src1", last_src1[sel],
                 (op == MUL_OP_LO) ? a : {16'h0, a[31:16]});
        check_eq("last_src2", last_src2[sel],
                 (op == MUL_OP_LO) ? b : {16'h0, b[31:16]});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int vcount;
        reset_n   = 1'b0;
        req_valid = '0;
        res_ready = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        #12;
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_req_ready", req_ready[s], 1);
            check_eq("rst_res_valid", res_valid[s], 0);
            check_eq("rst_cell_en", cell_en[s], 0);
            check_eq("rst_cell_src", {cell_src1[s], cell_src2[s]}, 64'h0);
            check_eq("rst_res_data", res_data[s], 0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            run_req(s, MUL_OP_LO,  32'h0001_0003, 32'h0002_0005, 4, 1'b0);
            run_req(s, MUL_OP_XUU, 32'h0001_0003, 32'h0002_0005, 0, 1'b0);
            run_req(s, MUL_OP_XSS, 32'hFFFF_FFFF, 32'h0000_0002, 1, 1'b1);
            run_req(s, MUL_OP_XUU, 32'hFFFF_FFFF, 32'h0000_0002, 2, 1'b0);
            run_req(s, MUL_OP_XSS, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
            run_req(s, MUL_OP_XSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0);
            for (int n = 0; n < 25; n++) begin
                run_req(s, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                        $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            end
            check_eq("src_zero_outside_issue", src_viol[s], 0);
        end

        // Abort a high op in WAIT_HI (latency-3 instance) with a mid-cycle reset.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_op[1]    = MUL_OP_XSS;
        req_a[1]     = 32'h1234_5678;
        req_b[1]     = 32'h8765_4321;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("abort_res_valid", res_valid[1], 0);
        check_eq("abort_req_ready", req_ready[1], 1);
        check_eq("abort_cell_en", cell_en[1], 0);
        check_eq("abort_cell_src", {cell_src1[1], cell_src2[1]}, 64'h0);
        check_eq("abort_res_data", res_data[1], 0);
        @(negedge clk);
        reset_n = 1'b1;
        vcount  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (res_valid[1]) vcount++;
        end
        check_eq("abort_no_res_valid", vcount, 0);
        run_req(1, MUL_OP_LO, 32'h3, 32'h5, 0, 1'b0);
        run_req(0, MUL_OP_LO, 32'h3, 32'h5, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_result_sequencer.md
Name: mul_result_sequencer

Overview:
- Multicycle controller and result assembler for the CPU multiply path.
- Accepts one 32x32 multiply request, drives the shared 16x16 partial-product cell and collects its three products (lo*lo, loA*hiB, hiA*loB).
- For high-word ops, runs a second cell pass to obtain hiA*hiB, then assembles the 32-bit low or high result with signed correction.
- Sits between E-stage operand issue and M/W-stage writeback.

Parameters:
- CELL_LATENCY, 1, cycles from a cell_en-qualified clock edge until cell_p1..p3 are valid; range 1..4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  0=MUL (low 32), 1=MULXUU, 2=MULXSS, 3=MULXSU (high 32)
- req_a  in  32  operand A
- req_b  in  32  operand B
- cell_src1  out  32  partial-product cell operand 1
- cell_src2  out  32  partial-product cell operand 2
- cell_en  out  1  partial-product cell register enable
- cell_p1  in  32  src1[15:0]*src2[15:0]
- cell_p2  in  32  src1[15:0]*src2[31:16]
- cell_p3  in  32  src1[31:16]*src2[15:0]
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  32  result word

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, req_ready=1, cell_en=0, cell_src1=cell_src2=0, res_valid=0, res_data=0, all internal registers 0.
- Request handshake: a request is accepted on a clk edge where req_valid && req_ready. req_a, req_b and req_op are latched at that edge. req_ready=1 only in IDLE.
- State IDLE: on accept, go to ISSUE_LO.
- State ISSUE_LO:
  - cell_src1=a, cell_src2=b, cell_en=1 for exactly one cycle.
  - Load wait counter with CELL_LATENCY-1, then go to WAIT_LO.
- State WAIT_LO:
  - cell_en=0, so the cell holds its products.
  - Decrement the counter. When it reaches 0, capture acc[48:0] = p1 + ((p2+p3) << 16), computed at 49-bit width with no truncation.
  - If op==MUL, load res_data=acc[31:0] and go to RESP. Otherwise go to ISSUE_HI.
- State ISSUE_HI:
  - cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1 for one cycle.
  - Reload the counter, then go to WAIT_HI.
- State WAIT_HI:
  - When the counter reaches 0, form the unsigned product full[63:0] = acc + (p1 << 32).
  - hi = full[63:32].
  - MULXSS: subtract (a[31]?b:0) and (b[31]?a:0) from hi.
  - MULXSU: subtract (a[31]?b:0) from hi.
  - All subtraction is modulo 2^32. Load res_data=hi, then go to RESP.
- State RESP:
  - res_valid=1; res_data is held stable.
  - On res_ready, go to IDLE and drop res_valid. The earliest new accept is on the following edge (no same-cycle turnaround).
- Latency with CELL_LATENCY=1, counted from the accept edge to the first cycle of res_valid=1: MUL 3 cycles, high ops 5 cycles.
- cell_en pulses exactly 1 time for MUL and 2 times for high ops per request, and is never asserted outside ISSUE_*.
- cell_src* are 0 outside ISSUE_* states.
- res_ready while not in RESP is ignored. req_valid while busy is ignored and the request is not latched.
- Reset asserted mid-operation aborts immediately: no res_valid pulse, and outputs take their reset values.
- Arithmetic is exact: 0xFFFFFFFF*0xFFFFFFFF must not overflow the internal acc/full widths.

Decomposition:
- Shared package mul_seq_pkg:
  - op encoding constants MUL_OP_LO=0, MUL_OP_XUU=1, MUL_OP_XSS=2, MUL_OP_XSU=3.
  - state enum IDLE/ISSUE_LO/WAIT_LO/ISSUE_HI/WAIT_HI/RESP.
- One combinational sub-module mul_hi_correct:
  - inputs: full[63:32], a, b, op; output: the corrected high word.
  - Kept separate so it can be unit-tested on its own.

Test Plan:
- MUL a=0x00010003, b=0x00020005 -> res_data=0x000B000F at 3 cycles; cell_en pulses once.
- MULXUU, same operands -> res_data=0x00000002 at 5 cycles; cell_en pulses twice; second-pass cell_src1=0x00000001, cell_src2=0x00000002.
- High-op sign cases:
  - MULXSS a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF
  - MULXUU, same operands -> 0x00000001
  - MULXSS a=b=0x80000000 -> 0x40000000
  - MULXSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF
- Back-pressure:
  - Hold res_ready=0 for 4 cycles after res_valid -> res_data stable, req_ready=0, and a req_valid pulse is ignored.
  - Release -> IDLE; the next request is accepted the cycle after.
- Reset during WAIT_HI (assert reset_n=0 mid-cycle) -> outputs reset asynchronously and no res_valid follows. A new MUL 0x3*0x5 afterwards -> 0x0000000F.
- CELL_LATENCY=3 with a cell model of matching delay -> MUL latency 5 cycles, high ops 9 cycles; results identical to CELL_LATENCY=1.
